// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns RV32I byte/half/word accesses into whole-word RAM
// cycles, merging store lanes and extending load data; word-crossing accesses take two cycles.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic [31:0]       rdata_o,
    output logic              rdata_valid_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);

    typedef enum logic {IDLE, SECOND} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] next_addr_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [31:0]       low_q;

    logic              in_second;
    logic [2:0]        cur_f3;
    logic [1:0]        cur_off;
    logic              cur_we;
    logic [31:0]       cur_wdata;
    logic [ADDR_W-1:0] base_addr;
    logic              legal;
    logic [3:0]        size_mask;
    logic [7:0]        byte_mask;
    logic [63:0]       bit_mask;
    logic              split;
    logic [4:0]        shamt;
    logic [63:0]       wdata_sh;
    logic [63:0]       load_word;
    logic [31:0]       ld_raw;
    logic [31:0]       ld_ext;
    logic [31:0]       merge_lo;
    logic [31:0]       merge_hi;
    logic              capture;

    // In SECOND the latched first-half fields replace the (ignored) inputs.
    assign in_second = (state == SECOND);
    assign cur_f3    = in_second ? f3_q    : funct3_i;
    assign cur_off   = in_second ? off_q   : addr_i[1:0];
    assign cur_we    = in_second ? we_q    : we_i;
    assign cur_wdata = in_second ? wdata_q : wdata_i;
    assign base_addr = {addr_i[ADDR_W-1:2], 2'b00};

    // Two adjacent words viewed as one 8-byte window; lanes 4..7 belong to the next word.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        legal     = 1'b0;
        size_mask = 4'b0000;
        unique case (cur_f3)
            3'b000: begin legal = 1'b1;    size_mask = 4'b0001; end
            3'b001: begin legal = 1'b1;    size_mask = 4'b0011; end
            3'b010: begin legal = 1'b1;    size_mask = 4'b1111; end
            3'b100: begin legal = !cur_we; size_mask = 4'b0001; end
            3'b101: begin legal = !cur_we; size_mask = 4'b0011; end
            default: ;
        endcase
        byte_mask = {4'b0000, size_mask} << cur_off;
        split     = |byte_mask[7:4];
        for (int i = 0; i < 8; i++) begin
            bit_mask[8*i +: 8] = {8{byte_mask[i]}};
        end
        shamt     = {cur_off, 3'b000};
        wdata_sh  = {32'b0, cur_wdata} << shamt;
        load_word = in_second ? {ram_rdata_i, low_q} : {32'b0, ram_rdata_i};
        ld_raw    = 32'(load_word >> shamt);
        unique case (cur_f3[1:0])
            2'b00:   ld_ext = {{24{!cur_f3[2] && ld_raw[7]}}, ld_raw[7:0]};
            2'b01:   ld_ext = {{16{!cur_f3[2] && ld_raw[15]}}, ld_raw[15:0]};
            default: ld_ext = ld_raw;
        endcase
        merge_lo = (ram_rdata_i & ~bit_mask[31:0])  | (wdata_sh[31:0]  & bit_mask[31:0]);
        merge_hi = (ram_rdata_i & ~bit_mask[63:32]) | (wdata_sh[63:32] & bit_mask[63:32]);
    end

    always_comb begin
        state_nxt     = state;
        stall_o       = 1'b0;
        rdata_o       = 32'b0;
        rdata_valid_o = 1'b0;
        ram_we_o      = 1'b0;
        ram_addr_o    = '0;
        ram_wdata_o   = 32'b0;
        capture       = 1'b0;
        if (rst) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    ram_addr_o = base_addr;
                    if (req_i && legal) begin
                        if (we_i) begin
                            ram_we_o    = 1'b1;
                            ram_wdata_o = merge_lo;
                        end else if (!split) begin
                            rdata_o       = ld_ext;
                            rdata_valid_o = 1'b1;
                        end
                        if (split) begin
                            stall_o   = 1'b1;
                            capture   = 1'b1;
                            state_nxt = SECOND;
                        end
                    end
                end
                SECOND: begin
                    ram_addr_o = next_addr_q;
                    state_nxt  = IDLE;
                    if (we_q) begin
                        ram_we_o    = 1'b1;
                        ram_wdata_o = merge_hi;
                    end else begin
                        rdata_o       = ld_ext;
                        rdata_valid_o = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            next_addr_q <= '0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            we_q        <= 1'b0;
            wdata_q     <= 32'b0;
            low_q       <= 32'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                next_addr_q <= base_addr + ADDR_W'(4);
                f3_q        <= funct3_i;
                off_q       <= addr_i[1:0];
                we_q        <= we_i;
                wdata_q     <= wdata_i;
                low_q       <= ram_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand sequences for wrap
// and reset-in-SECOND, then random accesses against a byte-level memory model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;

    int total = 0;
    int bad   = 0;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .we_i          (we_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .ram_we_o      (ram_we_o),
        .ram_addr_o    (ram_addr_o),
        .ram_wdata_o   (ram_wdata_o),
        .ram_rdata_i   (ram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small word RAM indexed by address bits [9:2], combinational read.
    logic [31:0] mem [256];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;
    assign ram_rdata_i = mem[ram_addr_o[9:2]];
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (ram_we_o) mem[ram_addr_o[9:2]] <= ram_wdata_o;
    end

    // Reference memory with the same aliasing as the RAM, addressed byte-wise.
    logic [31:0] ref_mem [256];

    function automatic logic [7:0] rbyte(input logic [31:0] a);
        logic [31:0] w;
        w = ref_mem[a[9:2]];
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    task automatic wbyte(input logic [31:0] a, input logic [7:0] b);
        logic [31:0] w;
        w = ref_mem[a[9:2]];
        w[{a[1:0], 3'b000} +: 8] = b;
        ref_mem[a[9:2]] = w;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        ref_mem[idx] = data;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    logic [31:0] op_rd, op_a_addr, op_b_addr, op_a_wdata;
    logic        op_vld, op_a_vld, op_a_we;
    int          op_stalls;

    // Presents one request at a negedge; scrambles inputs during any stall cycle, which the
    // DUT must ignore; returns just after the final commit edge with req_i low.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
        @(negedge clk);
        req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wdata;
        #1;
        op_a_addr  = ram_addr_o;
        op_a_we    = ram_we_o;
        op_a_wdata = ram_wdata_o;
        op_a_vld   = rdata_valid_o;
        op_b_addr  = ram_addr_o;
        op_stalls  = 0;
        while (stall_o && op_stalls < 4) begin
            op_stalls++;
            @(negedge clk);
            req_i = 1'($urandom); we_i = 1'($urandom); funct3_i = 3'($urandom);
            addr_i = $urandom; wdata_i = $urandom;
            #1;
            op_b_addr = ram_addr_o;
        end
        op_rd  = rdata_o;
        op_vld = rdata_valid_o;
        @(posedge clk);
        #1 req_i = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        exp_valid;
        logic [31:0] exp_rdata;
        logic [31:0] exp_w0;
        logic [31:0] exp_w1;
        int          exp_stalls;
    } vec_t;

    vec_t vecs[15];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; pl_en = 1'b0; pl_idx = 8'h0; pl_data = 32'h0;
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h102; wdata_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

        // Outputs held at zero during reset even with a split store presented.
        #12;
        check("rst_stall", {31'b0, stall_o}, 32'h0);
        check("rst_we", {31'b0, ram_we_o}, 32'h0);
        check("rst_valid", {31'b0, rdata_valid_o}, 32'h0);
        check("rst_addr", ram_addr_o, 32'h0);
        check("rst_wdata", ram_wdata_o, 32'h0);
        @(negedge clk);
        rst = 1'b0; req_i = 1'b0;

        vecs[0]  = '{1'b0, 3'b000, 32'h101, 32'h0, 32'h80AABBCC, 32'h0, 1'b1, 32'hFFFFFFBB, 32'h80AABBCC, 32'h0, 0};
        vecs[1]  = '{1'b0, 3'b100, 32'h101, 32'h0, 32'h80AABBCC, 32'h0, 1'b1, 32'h000000BB, 32'h80AABBCC, 32'h0, 0};
        vecs[2]  = '{1'b0, 3'b001, 32'h102, 32'h0, 32'h80AABBCC, 32'h0, 1'b1, 32'hFFFF80AA, 32'h80AABBCC, 32'h0, 0};
        vecs[3]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'h80AABBCC, 32'h0, 1'b1, 32'h80AABBCC, 32'h80AABBCC, 32'h0, 0};
        vecs[4]  = '{1'b1, 3'b000, 32'h103, 32'h5A, 32'h12345678, 32'h0, 1'b0, 32'h0, 32'h5A345678, 32'h0, 0};
        vecs[5]  = '{1'b1, 3'b001, 32'h100, 32'hBEEF, 32'h12345678, 32'h0, 1'b0, 32'h0, 32'h1234BEEF, 32'h0, 0};
        vecs[6]  = '{1'b1, 3'b010, 32'h102, 32'h11223344, 32'hAAAAAAAA, 32'hBBBBBBBB, 1'b0, 32'h0, 32'h3344AAAA, 32'hBBBB1122, 1};
        vecs[7]  = '{1'b0, 3'b001, 32'h103, 32'h0, 32'h80AABBCC, 32'hDDEEFF81, 1'b1, 32'hFFFF8180, 32'h80AABBCC, 32'hDDEEFF81, 1};
        vecs[8]  = '{1'b0, 3'b101, 32'h103, 32'h0, 32'h80AABBCC, 32'hDDEEFF81, 1'b1, 32'h00008180, 32'h80AABBCC, 32'hDDEEFF81, 1};
        vecs[9]  = '{1'b0, 3'b010, 32'h101, 32'h0, 32'h80AABBCC, 32'hDDEEFF81, 1'b1, 32'h8180AABB, 32'h80AABBCC, 32'hDDEEFF81, 1};
        vecs[10] = '{1'b1, 3'b011, 32'h100, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 0};
        vecs[11] = '{1'b1, 3'b100, 32'h103, 32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 0};
        vecs[12] = '{1'b0, 3'b110, 32'h100, 32'h0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 0};
        vecs[13] = '{1'b1, 3'b001, 32'h103, 32'hCAFE, 32'h11111111, 32'h22222222, 1'b0, 32'h0, 32'hFE111111, 32'h222222CA, 1};
        vecs[14] = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h7F000000, 32'h0, 1'b1, 32'h0000007F, 32'h7F000000, 32'h0, 0};

        for (int i = 0; i < 15; i++) begin
            preload(8'h40, vecs[i].w0);
            preload(8'h41, vecs[i].w1);
            run_op(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_valid", i), {31'b0, op_vld}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) check($sformatf("vec%0d_rdata", i), op_rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_stalls", i), op_stalls, vecs[i].exp_stalls);
            check($sformatf("vec%0d_addr_a", i), op_a_addr, 32'h100);
            if (vecs[i].exp_stalls == 1) begin
                check($sformatf("vec%0d_valid_a", i), {31'b0, op_a_vld}, 32'h0);
                check($sformatf("vec%0d_addr_b", i), op_b_addr, 32'h104);
            end
            check($sformatf("vec%0d_w0", i), mem[8'h40], vecs[i].exp_w0);
            check($sformatf("vec%0d_w1", i), mem[8'h41], vecs[i].exp_w1);
        end

        // Split SW first-half write contents.
        preload(8'h40, 32'hAAAAAAAA);
        preload(8'h41, 32'hBBBBBBBB);
        run_op(1'b1, 3'b010, 32'h102, 32'h11223344);
        check("sw_a_we", {31'b0, op_a_we}, 32'h1);
        check("sw_a_wdata", op_a_wdata, 32'h3344AAAA);

        // Split load wrapping past the top of the address space.
        preload(8'hFF, 32'h44332211);
        preload(8'h00, 32'h88776655);
        run_op(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
        check("wrap_addr_a", op_a_addr, 32'hFFFFFFFC);
        check("wrap_addr_b", op_b_addr, 32'h00000000);
        check("wrap_rdata", op_rd, 32'h66554433);
        check("wrap_stalls", op_stalls, 1);

        // Reset asserted during SECOND of a split store.
        preload(8'h40, 32'hAAAAAAAA);
        preload(8'h41, 32'hBBBBBBBB);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h102; wdata_i = 32'h11223344;
        #1 check("rs_first_stall", {31'b0, stall_o}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rs_we", {31'b0, ram_we_o}, 32'h0);
        check("rs_stall", {31'b0, stall_o}, 32'h0);
        check("rs_valid", {31'b0, rdata_valid_o}, 32'h0);
        check("rs_addr", ram_addr_o, 32'h0);
        check("rs_wdata", ram_wdata_o, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0; req_i = 1'b0;
        check("rs_w0", mem[8'h40], 32'h3344AAAA);
        check("rs_w1", mem[8'h41], 32'hBBBBBBBB);
        run_op(1'b0, 3'b010, 32'h104, 32'h0);
        check("rs_idle_rdata", op_rd, 32'hBBBBBBBB);
        check("rs_idle_stalls", op_stalls, 0);

        // Random accesses against the byte-level model; ops run back to back.
        for (int i = 0; i < 6; i++) preload(8'(8'h40 + i), $urandom);
        preload(8'hFE, $urandom);
        preload(8'hFF, $urandom);
        preload(8'h00, $urandom);
        for (int n = 0; n < 400; n++) begin
            logic        we, legal, signed_ld;
            logic [2:0]  f3;
            logic [31:0] addr, wdata, exp_rd, nxt;
            int          size, exp_st;
            case ($urandom_range(0, 3))
                0: addr = 32'h100;
                1: addr = 32'h108;
                2: addr = 32'h110 - 8;
                default: addr = 32'hFFFFFFF8;
            endcase
            addr  = addr + $urandom_range(0, 7);
            we    = 1'($urandom);
            f3    = 3'($urandom_range(0, 7));
            wdata = $urandom;
            size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
            legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) ||
                    (!we && (f3 == 3'b100 || f3 == 3'b101));
            signed_ld = !f3[2];
            exp_st = (legal && (int'(addr[1:0]) + size > 4)) ? 1 : 0;
            exp_rd = 32'h0;
            if (legal && !we) begin
                for (int b = 0; b < size; b++) exp_rd[8*b +: 8] = rbyte(addr + b);
                if (signed_ld && size == 1) exp_rd = {{24{exp_rd[7]}}, exp_rd[7:0]};
                if (signed_ld && size == 2) exp_rd = {{16{exp_rd[15]}}, exp_rd[15:0]};
            end
            if (legal && we) begin
                for (int b = 0; b < size; b++) wbyte(addr + b, wdata[8*b +: 8]);
            end
            run_op(we, f3, addr, wdata);
            check($sformatf("rnd%0d_valid", n), {31'b0, op_vld}, {31'b0, legal && !we});
            if (legal && !we) check($sformatf("rnd%0d_rdata", n), op_rd, exp_rd);
            check($sformatf("rnd%0d_stalls", n), op_stalls, exp_st);
            nxt = addr + 4;
            check($sformatf("rnd%0d_w0", n), mem[addr[9:2]], ref_mem[addr[9:2]]);
            check($sformatf("rnd%0d_w1", n), mem[nxt[9:2]], ref_mem[nxt[9:2]]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
